// File: rtl/mux7_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mux7_rr_scheduler_if
// Purpose  : Bundles the request/grant/select signals between the seven
//            requesters and the round-robin scheduler that owns the mux select.
// Signals  : req        [6:0] level request, bit i = requester i wants the mux
//            grant      [6:0] one-hot current owner, zero when no owner
//            mux_select [2:0] select for the 7-to-1 mux (0..6)
//            valid            mux output belongs to the granted requester
// Modports : master - requester side (drives req)
//            slave  - scheduler side (drives grant/mux_select/valid)
// Revision : 1.0 - initial release
// ============================================================================
interface mux7_rr_scheduler_if;
  logic [6:0] req;
  logic [6:0] grant;
  logic [2:0] mux_select;
  logic       valid;

  modport master (
    output req,
    input  grant,
    input  mux_select,
    input  valid
  );

  modport slave (
    input  req,
    output grant,
    output mux_select,
    output valid
  );
endinterface
`default_nettype wire

// File: rtl/mux7_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mux7_rr_scheduler
// Purpose  : Round-robin scheduler sharing one 7-to-1 mux among 7 requesters.
//            Each ownership lasts at most HOLD_CYCLES cycles and is followed
//            by one idle GAP cycle before the next arbitration.
// Ports    : clock  - system clock, rising edge
//            resetn - asynchronous active-low reset
//            bus    - slave modport of mux7_rr_scheduler_if
//                     (req in; grant, mux_select, valid out, all registered)
// Params   : HOLD_CYCLES - max consecutive GRANT cycles per ownership (1..15)
// Revision : 1.0 - initial release
// ============================================================================
module mux7_rr_scheduler #(
  parameter int HOLD_CYCLES = 4
) (
  input  wire logic             clock,
  input  wire logic             resetn,
  mux7_rr_scheduler_if.slave    bus
);

  localparam logic [3:0] c_hold_max = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr,   w_ptr_nxt;
  logic [3:0] r_hold,  w_hold_nxt;
  logic [6:0] r_grant, w_grant_nxt;
  logic [2:0] r_sel,   w_sel_nxt;
  logic       r_valid, w_valid_nxt;

  logic       w_found;
  logic [2:0] w_winner;
  logic [3:0] w_idx;

  // Search upward from r_ptr, wrapping 6->0; the first set request wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = 4'd0;
    for (int k = 0; k < 7; k++) begin
      w_idx = {1'b0, r_ptr} + 4'(k);
      if (w_idx >= 4'd7) begin
        w_idx = w_idx - 4'd7;
      end
      if (!w_found && bus.req[w_idx[2:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[2:0];
      end
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that grant, mux_select and valid all come straight from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;

    case (r_state)
      ST_GRANT: begin
        // r_sel is the current owner; release or hold limit both end it.
        if (!bus.req[r_sel] || (r_hold == c_hold_max)) begin
          w_state_nxt = ST_GAP;
          w_grant_nxt = 7'd0;
          w_valid_nxt = 1'b0;
        end else if (r_hold < c_hold_max) begin
          w_hold_nxt = r_hold + 4'd1;
        end
      end

      default: begin
        // IDLE and GAP arbitrate identically; mux_select keeps the last owner.
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_ptr_nxt   = (w_winner == 3'd6) ? 3'd0 : (w_winner + 3'd1);
          w_hold_nxt  = 4'd1;
          w_grant_nxt = 7'd1 << w_winner;
          w_sel_nxt   = w_winner;
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 7'd0;
          w_valid_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_hold  <= 4'd0;
      r_grant <= 7'd0;
      r_sel   <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.mux_select = r_sel;
  assign bus.valid      = r_valid;

endmodule
`default_nettype wire
